// File: rtl/mips32_pkg.sv
// Shared types and constants for the MIPS32 boot loader.
// Optional feature macro: MIPS32_LOADER_CHECKSUM_EN (see mips32_prog_loader).
package mips32_pkg;

    localparam int         WORD_W        = 32;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_ADDR,
        ST_HDR_CNT,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } ld_state_e;

    function automatic logic [32:0] mem_depth(input int addr_w);
        mem_depth = 33'd1 << addr_w;
    endfunction

endpackage

// File: rtl/mips32_byte_assembler.sv
// MSB-first byte-to-word assembler shared by header, data and checksum.
// word is valid together with word_done (includes the current byte).
module mips32_byte_assembler
    import mips32_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_fire,
    input  logic [7:0]        in_data,
    output logic              word_done,
    output logic [WORD_W-1:0] word
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  idx_q, idx_d;

    // Shift in accepted bytes and track position within the word.
    always_comb begin
        shift_d   = shift_q;
        idx_d     = idx_q;
        word      = {shift_q, in_data};
        word_done = in_fire && (idx_q == 2'd3);
        if (clr) begin
            shift_d = '0;
            idx_d   = '0;
        end else if (in_fire) begin
            shift_d = {shift_q[15:0], in_data};
            idx_d   = idx_q + 2'd1;
        end
    end

    // Assembler state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/mips32_prog_loader.sv
// Boot loader: byte stream -> big-endian words -> core memory, then release.
// Define MIPS32_LOADER_CHECKSUM_EN to require a 32-bit sum trailer.
module mips32_prog_loader
    import mips32_pkg::*;
#(
    parameter int         ADDR_W    = 10,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              restart,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    output logic [31:0]       pc_init,
    output logic              busy,
    output logic              err
);

    localparam logic [32:0] DEPTH = mem_depth(ADDR_W);
`ifdef MIPS32_LOADER_CHECKSUM_EN
    localparam ld_state_e AFTER_DATA = ST_CHK;
`else
    localparam ld_state_e AFTER_DATA = ST_DONE;
`endif

    ld_state_e         state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [31:0]       n_q, n_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
`ifdef MIPS32_LOADER_CHECKSUM_EN
    logic [31:0]       sum_q, sum_d;
`endif

    logic              fire;
    logic              asm_clr;
    logic              word_done;
    logic [WORD_W-1:0] word;
    logic [32:0]       end_addr;
    logic              hdr_bad;

    assign in_ready  = (state_q != ST_DONE) && (state_q != ST_ERR);
    assign fire      = in_valid && in_ready;
    assign busy      = (state_q != ST_IDLE) && in_ready;
    assign err       = (state_q == ST_ERR);
    assign cpu_run   = (state_q == ST_DONE) && !mem_we_q;
    assign pc_init   = cpu_run ? addr_q : '0;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    assign end_addr = {1'b0, addr_q} + {1'b0, word};
    assign hdr_bad  = ({1'b0, addr_q} >= DEPTH) || (end_addr > DEPTH);

    mips32_byte_assembler u_asm (
        .clk       (clk1),
        .rst_n     (rst_n),
        .clr       (asm_clr),
        .in_fire   (fire),
        .in_data   (in_data),
        .word_done (word_done),
        .word      (word)
    );

    // Frame sequencing, header range check and write generation.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        asm_clr     = 1'b0;
`ifdef MIPS32_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                asm_clr = 1'b1;
                if (fire && in_data == SYNC_BYTE) begin
                    state_d = ST_HDR_ADDR;
                    n_d     = '0;
`ifdef MIPS32_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            ST_HDR_ADDR: begin
                if (word_done) begin
                    addr_d  = word;
                    state_d = ST_HDR_CNT;
                end
            end
            ST_HDR_CNT: begin
                if (word_done) begin
                    cnt_d = word;
                    if (hdr_bad)
                        state_d = ST_ERR;
                    else if (word == '0)
                        state_d = AFTER_DATA;
                    else
                        state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (word_done) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ADDR_W'(addr_q + n_q);
                    mem_wdata_d = word;
                    n_d         = n_q + 32'd1;
`ifdef MIPS32_LOADER_CHECKSUM_EN
                    sum_d       = sum_q + word;
`endif
                    if (n_q + 32'd1 == cnt_q)
                        state_d = AFTER_DATA;
                end
            end
`ifdef MIPS32_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (word_done)
                    state_d = (word == sum_q) ? ST_DONE : ST_ERR;
            end
`endif
            ST_DONE, ST_ERR: begin
                if (restart)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Loader state register.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            n_q         <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef MIPS32_LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef MIPS32_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

endmodule
